// File: rtl/spin_adder16.sv
// 16-bit registered adder: two-level 4x4 lookahead carry unit feeding per-bit
// three-input parity cells, with a single result register and valid flag.

module control16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y,
  output logic        c16
);
  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  cg;

  assign g = a & b;
  assign p = a ^ b;

  // Second level: carries into each group; the design has no carry-in port.
  assign cg[0] = 1'b0;
  assign cg[1] = grp_g[0] | (grp_p[0] & cg[0]);
  assign cg[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cg[0]);
  assign cg[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[2] & grp_p[1] & grp_p[0] & cg[0]);
  assign cg[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cg[0]);
  assign c16 = cg[4];

  for (genvar k = 0; k < 4; k++) begin : grp
    logic [3:0] gg;
    logic [3:0] pp;
    logic       ci;

    assign gg = g[4*k +: 4];
    assign pp = p[4*k +: 4];
    assign ci = cg[k];

    assign grp_g[k] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                    | (pp[3] & pp[2] & pp[1] & gg[0]);
    assign grp_p[k] = &pp;

    assign y[4*k]     = ci;
    assign y[4*k + 1] = gg[0] | (pp[0] & ci);
    assign y[4*k + 2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
    assign y[4*k + 3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                      | (pp[2] & pp[1] & pp[0] & ci);
  end
endmodule

module modifiedxor (
  input  logic a,
  input  logic b,
  input  logic y,
  output logic s
);
  assign s = a ^ b ^ y;
endmodule

module spin_adder16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] s,
  output logic        cout,
  output logic        out_valid
);
  logic [15:0] y;
  logic        c16;
  logic [15:0] s_comb;
  logic [15:0] s_p1;
  logic        cout_p1;
  logic        vld_p1;

  control16 u_control (
    .a   (a),
    .b   (b),
    .y   (y),
    .c16 (c16)
  );

  for (genvar i = 0; i < 16; i++) begin : bitcell
    modifiedxor u_mx (
      .a (a[i]),
      .b (b[i]),
      .y (y[i]),
      .s (s_comb[i])
    );
  end

  // Stage p0 -> p1: result register; data holds when no new operand pair arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_p1    <= '0;
      cout_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        s_p1    <= s_comb;
        cout_p1 <= c16;
      end
    end
  end

  assign s         = s_p1;
  assign cout      = cout_p1;
  assign out_valid = vld_p1;
endmodule

// File: tb/tb_spin_adder16.sv
// Directed and random bench for spin_adder16 with immediate-assertion checks.

module tb_spin_adder16;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] s;
  logic        cout;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;

  spin_adder16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .s         (s),
    .cout      (cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input string tag, input logic [15:0] es, input logic ec, input logic ev);
    checks++;
    assert (s === es) else begin
      failures++;
      $error("FAIL %s.s observed=%h expected=%h", tag, s, es);
    end
    checks++;
    assert (cout === ec) else begin
      failures++;
      $error("FAIL %s.cout observed=%b expected=%b", tag, cout, ec);
    end
    checks++;
    assert (out_valid === ev) else begin
      failures++;
      $error("FAIL %s.out_valid observed=%b expected=%b", tag, out_valid, ev);
    end
  endtask

  // Drive inputs, advance one rising edge, sample 1 time unit later.
  task automatic step(input logic v, input logic [15:0] va, input logic [15:0] vb);
    in_valid = v;
    a        = va;
    b        = vb;
    @(posedge clk);
    #1;
  endtask

  logic [16:0] ref_sum;
  logic [15:0] exp_s;
  logic        exp_c;
  logic        v;
  logic [15:0] ra;
  logic [15:0] rb;

  initial begin
    // Reset held with a full-carry operand pair presented
    rst_n = 1'b0; in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001;
    #1;
    expect_out("reset_immediate", 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    expect_out("reset_edge1", 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    expect_out("reset_edge2", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;

    step(1'b1, 16'd16, 16'd15);
    expect_out("basic_16_15", 16'd31, 1'b0, 1'b1);
    step(1'b1, 16'd11, 16'd21);
    expect_out("basic_11_21", 16'd32, 1'b0, 1'b1);
    step(1'b1, 16'hFFFF, 16'h0001);
    expect_out("full_prop", 16'h0000, 1'b1, 1'b1);
    step(1'b1, 16'h7FFF, 16'h0001);
    expect_out("prop_15", 16'h8000, 1'b0, 1'b1);
    step(1'b1, 16'h000F, 16'h0001);
    expect_out("grp_bound_4", 16'h0010, 1'b0, 1'b1);
    step(1'b1, 16'h0FFF, 16'h0001);
    expect_out("grp_bound_12", 16'h1000, 1'b0, 1'b1);
    step(1'b1, 16'hFFFF, 16'hFFFF);
    expect_out("max_max", 16'hFFFE, 1'b1, 1'b1);
    step(1'b1, 16'h00FF, 16'h0001);
    expect_out("grp_bound_8", 16'h0100, 1'b0, 1'b1);
    step(1'b1, 16'h8000, 16'h8000);
    expect_out("msb_gen", 16'h0000, 1'b1, 1'b1);

    // Hold: result and carry stay while inputs change without in_valid
    step(1'b0, 16'h1234, 16'h4321);
    expect_out("hold1", 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'hAAAA, 16'h5555);
    expect_out("hold2", 16'h0000, 1'b1, 1'b0);
    step(1'b1, 16'hAAAA, 16'h5555);
    expect_out("after_hold", 16'hFFFF, 1'b0, 1'b1);

    // Mid-stream asynchronous reset discards the pending pair
    in_valid = 1'b1; a = 16'h1234; b = 16'h1111;
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("mid_reset_immediate", 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    expect_out("mid_reset_edge", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 16'h1234, 16'h1111);
    expect_out("post_reset", 16'h2345, 1'b0, 1'b1);

    exp_s = 16'h2345;
    exp_c = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #1;
        expect_out("rand_reset", 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        expect_out("rand_reset_edge", 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        exp_s = 16'h0000;
        exp_c = 1'b0;
      end
      v  = ($urandom_range(0, 7) != 0);
      ra = 16'($urandom);
      rb = 16'($urandom);
      step(v, ra, rb);
      if (v) begin
        ref_sum = {1'b0, ra} + {1'b0, rb};
        exp_s   = ref_sum[15:0];
        exp_c   = ref_sum[16];
      end
      expect_out("random", exp_s, exp_c, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
